// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with a 2-entry LSU result
// FIFO onto one register-file write port, with anti-starvation and pending tracking.
module wb_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst,
  input  logic                  alu_wb_valid,
  input  logic [4:0]            alu_wb_rd,
  input  logic [DATA_WIDTH-1:0] alu_wb_data,
  output logic                  alu_wb_stall,
  input  logic                  lsu_issue_valid,
  input  logic [4:0]            lsu_issue_rd,
  input  logic                  lsu_wb_valid,
  output logic                  lsu_wb_ready,
  input  logic [4:0]            lsu_wb_rd,
  input  logic [DATA_WIDTH-1:0] lsu_wb_data,
  output logic                  wr_valid,
  output logic [4:0]            rd_wb,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [4:0]            rs1_dec,
  input  logic [4:0]            rs2_dec,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]            fifo_rd   [2];
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  wptr;
  logic                  rptr;
  logic [1:0]            count;
  logic [SW-1:0]         starve;
  logic [31:0]           pending;
  logic [31:0]           pending_next;

  logic                  has_head;
  logic                  alu_win;
  logic                  push;
  logic                  pop;
  logic [4:0]            head_rd;
  logic [DATA_WIDTH-1:0] head_data;

  // Ready and stall look only at registered state so a same-cycle pop never frees a slot.
  always_comb begin
    has_head     = (count != 2'd0);
    head_rd      = fifo_rd[rptr];
    head_data    = fifo_data[rptr];
    lsu_wb_ready = !cpu_rst && (count < 2'd2);
    alu_wb_stall = !cpu_rst && has_head && (starve == SW'(STARVE_LIMIT));
    alu_win      = alu_wb_valid && (alu_wb_rd != 5'd0) && !alu_wb_stall;
    pop          = has_head && !alu_win;
    push         = lsu_wb_valid && lsu_wb_ready;
  end

  // Set is applied after clear so a same-cycle issue to the popped index stays pending.
  always_comb begin
    pending_next = pending;
    if (pop && (head_rd != 5'd0))
      pending_next[head_rd] = 1'b0;
    if (lsu_issue_valid && (lsu_issue_rd != 5'd0))
      pending_next[lsu_issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_comb begin
    rs1_busy = pending[rs1_dec];
    rs2_busy = pending[rs2_dec];
  end

  always_ff @(posedge cpu_clk) begin
    if (push) begin
      fifo_rd[wptr]   <= lsu_wb_rd;
      fifo_data[wptr] <= lsu_wb_data;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      count    <= 2'd0;
      starve   <= '0;
      pending  <= '0;
      wr_valid <= 1'b0;
      rd_wb    <= '0;
      wr_data  <= '0;
    end else begin
      if (push)
        wptr <= ~wptr;
      if (pop)
        rptr <= ~rptr;

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase

      if (!has_head || pop)
        starve <= '0;
      else if (starve != SW'(STARVE_LIMIT))
        starve <= starve + SW'(1);

      if (alu_win) begin
        wr_valid <= 1'b1;
        rd_wb    <= alu_wb_rd;
        wr_data  <= alu_wb_data;
      end else if (pop) begin
        wr_valid <= (head_rd != 5'd0);
        rd_wb    <= head_rd;
        wr_data  <= head_data;
      end else begin
        wr_valid <= 1'b0;
      end

      pending <= pending_next;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writes are queued as stimulus is
// driven and matched against every observed register-file write.
module tb_wb_arbiter;

  localparam int DW = 32;

  logic          cpu_clk = 1'b0;
  logic          cpu_rst;
  logic          alu_wb_valid;
  logic [4:0]    alu_wb_rd;
  logic [DW-1:0] alu_wb_data;
  logic          alu_wb_stall;
  logic          lsu_issue_valid;
  logic [4:0]    lsu_issue_rd;
  logic          lsu_wb_valid;
  logic          lsu_wb_ready;
  logic [4:0]    lsu_wb_rd;
  logic [DW-1:0] lsu_wb_data;
  logic          wr_valid;
  logic [4:0]    rd_wb;
  logic [DW-1:0] wr_data;
  logic [4:0]    rs1_dec;
  logic [4:0]    rs2_dec;
  logic          rs1_busy;
  logic          rs2_busy;

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  wb_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_stall(alu_wb_stall),
    .lsu_issue_valid(lsu_issue_valid), .lsu_issue_rd(lsu_issue_rd),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
    .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .wr_valid(wr_valid), .rd_wb(rd_wb), .wr_data(wr_data),
    .rs1_dec(rs1_dec), .rs2_dec(rs2_dec), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Scoreboard: every observed write must match the oldest expected write.
  always @(negedge cpu_clk) begin
    wb_t e;
    if (wr_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: write rd=%0d data=%h, expected no write", rd_wb, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({rd_wb, wr_data} !== {e.rd, e.data}) begin
          n_fail++;
          $display("FAIL sb_write: got rd=%0d data=%h, expected rd=%0d data=%h", rd_wb, wr_data, e.rd, e.data);
        end
      end
    end
  end

  task automatic tick;
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle;
    alu_wb_valid = 1'b0; alu_wb_rd = '0; alu_wb_data = '0;
    lsu_issue_valid = 1'b0; lsu_issue_rd = '0;
    lsu_wb_valid = 1'b0; lsu_wb_rd = '0; lsu_wb_data = '0;
  endtask

  task automatic test_reset;
    cpu_rst = 1'b1; idle(); rs1_dec = 5'd5; rs2_dec = 5'd6;
    repeat (3) tick();
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b, expected 0", wr_valid); end
    n_checks++; if (lsu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, expected 0", lsu_wb_ready); end
    n_checks++; if (alu_wb_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, expected 0", alu_wb_stall); end
    n_checks++; if ({rs1_busy, rs2_busy} !== 2'b00) begin n_fail++; $display("FAIL reset_busy: got %b, expected 00", {rs1_busy, rs2_busy}); end
    cpu_rst = 1'b0;
    tick();
    n_checks++; if (lsu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b, expected 1", lsu_wb_ready); end
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL release_wr_valid: got %b, expected 0", wr_valid); end
  endtask

  task automatic test_alu;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'h1234;
    exp_q.push_back('{rd: 5'd5, data: 32'h1234});
    tick();
    idle();
    n_checks++; if ({wr_valid, rd_wb, wr_data} !== {1'b1, 5'd5, 32'h1234}) begin n_fail++;
      $display("FAIL alu_latency: got v=%b rd=%0d d=%h, expected v=1 rd=5 d=1234", wr_valid, rd_wb, wr_data); end
    tick();
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL alu_single_cycle: got %b, expected 0", wr_valid); end
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'hBEEF;
    tick();
    idle();
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL alu_rd0: got %b, expected 0", wr_valid); end
    tick();
  endtask

  task automatic test_lsu_busy;
    lsu_issue_valid = 1'b1; lsu_issue_rd = 5'd7;
    tick();
    idle(); rs1_dec = 5'd7; rs2_dec = 5'd0;
    #1;
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL busy_set: got %b, expected 1", rs1_busy); end
    n_checks++; if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL busy_x0: got %b, expected 0", rs2_busy); end
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd7; lsu_wb_data = 32'hCAFE;
    #1;
    n_checks++; if (lsu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL lsu_ready: got %b, expected 1", lsu_wb_ready); end
    exp_q.push_back('{rd: 5'd7, data: 32'hCAFE});
    tick();
    idle();
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL lsu_no_bypass: got %b, expected 0", wr_valid); end
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL busy_hold: got %b, expected 1", rs1_busy); end
    tick();
    n_checks++; if ({wr_valid, rd_wb, wr_data} !== {1'b1, 5'd7, 32'hCAFE}) begin n_fail++;
      $display("FAIL lsu_latency: got v=%b rd=%0d d=%h, expected v=1 rd=7 d=cafe", wr_valid, rd_wb, wr_data); end
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL busy_clear: got %b, expected 0", rs1_busy); end
    tick();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'(11 + i); lsu_wb_data = 32'hB000 + 32'(i);
        exp_q.push_back('{rd: 5'(11 + i), data: 32'hB000 + 32'(i)});
      end else begin
        lsu_wb_valid = 1'b0;
      end
      #1;
      if (i < 3) begin
        n_checks++; if (lsu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b, expected 1", i, lsu_wb_ready); end
      end
      if (i >= 2 && i < 5) begin
        n_checks++; if ({wr_valid, rd_wb} !== {1'b1, 5'(9 + i)}) begin n_fail++;
          $display("FAIL b2b_write[%0d]: got v=%b rd=%0d, expected v=1 rd=%0d", i, wr_valid, rd_wb, 9 + i); end
      end
      if (i == 5) begin
        n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b, expected 0", wr_valid); end
      end
      tick();
    end
  endtask

  task automatic test_starvation;
    for (int i = 0; i < 9; i++) begin
      alu_wb_valid = (i <= 6); alu_wb_rd = 5'd9;
      alu_wb_data  = 32'hA000 + 32'((i < 6) ? i : 5);
      lsu_wb_valid = (i < 2); lsu_wb_rd = 5'd10; lsu_wb_data = 32'hC000 + 32'(i);
      if (i <= 4) exp_q.push_back('{rd: 5'd9, data: 32'hA000 + 32'(i)});
      if (i == 5) exp_q.push_back('{rd: 5'd10, data: 32'hC000});
      if (i == 6) exp_q.push_back('{rd: 5'd9, data: 32'hA005});
      if (i == 7) exp_q.push_back('{rd: 5'd10, data: 32'hC001});
      #1;
      if (i == 2) begin
        n_checks++; if (lsu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL starve_full: got %b, expected 0", lsu_wb_ready); end
      end
      if (i < 5) begin
        n_checks++; if (alu_wb_stall !== 1'b0) begin n_fail++; $display("FAIL starve_early[%0d]: got %b, expected 0", i, alu_wb_stall); end
      end
      if (i == 5) begin
        n_checks++; if (alu_wb_stall !== 1'b1) begin n_fail++; $display("FAIL starve_stall: got %b, expected 1", alu_wb_stall); end
        n_checks++; if (lsu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL starve_ready_pop: got %b, expected 0", lsu_wb_ready); end
      end
      if (i == 6) begin
        n_checks++; if (alu_wb_stall !== 1'b0) begin n_fail++; $display("FAIL starve_release: got %b, expected 0", alu_wb_stall); end
        n_checks++; if (lsu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL starve_ready_free: got %b, expected 1", lsu_wb_ready); end
        n_checks++; if ({wr_valid, rd_wb} !== {1'b1, 5'd10}) begin n_fail++;
          $display("FAIL starve_head: got v=%b rd=%0d, expected v=1 rd=10", wr_valid, rd_wb); end
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_priority;
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd12; lsu_wb_data = 32'hD012;
    tick();
    idle(); alu_wb_valid = 1'b1; alu_wb_rd = 5'd13; alu_wb_data = 32'hA013;
    exp_q.push_back('{rd: 5'd13, data: 32'hA013});
    exp_q.push_back('{rd: 5'd12, data: 32'hD012});
    tick();
    idle();
    n_checks++; if ({wr_valid, rd_wb} !== {1'b1, 5'd13}) begin n_fail++; $display("FAIL prio_alu_first: got v=%b rd=%0d, expected v=1 rd=13", wr_valid, rd_wb); end
    tick();
    n_checks++; if ({wr_valid, rd_wb} !== {1'b1, 5'd12}) begin n_fail++; $display("FAIL prio_head_next: got v=%b rd=%0d, expected v=1 rd=12", wr_valid, rd_wb); end
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd14; lsu_wb_data = 32'hD014;
    exp_q.push_back('{rd: 5'd14, data: 32'hD014});
    tick();
    idle(); alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'hA000;
    tick();
    idle();
    n_checks++; if ({wr_valid, rd_wb} !== {1'b1, 5'd14}) begin n_fail++; $display("FAIL prio_alu_rd0: got v=%b rd=%0d, expected v=1 rd=14", wr_valid, rd_wb); end
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd0; lsu_wb_data = 32'hFFFF;
    tick();
    idle();
    tick();
    n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL head_rd0: got %b, expected 0", wr_valid); end
    tick();
  endtask

  task automatic test_set_clear;
    rs1_dec = 5'd3;
    lsu_issue_valid = 1'b1; lsu_issue_rd = 5'd3;
    tick();
    idle(); alu_wb_valid = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'hA003;
    exp_q.push_back('{rd: 5'd3, data: 32'hA003});
    tick();
    idle();
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL alu_keeps_pending: got %b, expected 1", rs1_busy); end
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd3; lsu_wb_data = 32'h0033;
    exp_q.push_back('{rd: 5'd3, data: 32'h0033});
    tick();
    idle(); lsu_issue_valid = 1'b1; lsu_issue_rd = 5'd3;
    tick();
    idle();
    n_checks++; if ({wr_valid, rd_wb} !== {1'b1, 5'd3}) begin n_fail++; $display("FAIL setclr_write: got v=%b rd=%0d, expected v=1 rd=3", wr_valid, rd_wb); end
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL set_over_clear: got %b, expected 1", rs1_busy); end
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd3; lsu_wb_data = 32'h0034;
    exp_q.push_back('{rd: 5'd3, data: 32'h0034});
    tick();
    idle();
    tick();
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL later_clear: got %b, expected 0", rs1_busy); end
    tick();
  endtask

  task automatic test_reset_midop;
    for (int i = 0; i < 3; i++) begin
      alu_wb_valid = 1'b1; alu_wb_rd = 5'd1; alu_wb_data = 32'h100 + 32'(i);
      exp_q.push_back('{rd: 5'd1, data: 32'h100 + 32'(i)});
      lsu_issue_valid = (i < 2); lsu_issue_rd = 5'(20 + i);
      lsu_wb_valid = (i < 2); lsu_wb_rd = 5'(20 + i); lsu_wb_data = 32'hE000 + 32'(i);
      if (i == 2) begin
        rs1_dec = 5'd20; rs2_dec = 5'd21;
        #1;
        n_checks++; if (lsu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL midop_full: got %b, expected 0", lsu_wb_ready); end
        n_checks++; if ({rs1_busy, rs2_busy} !== 2'b11) begin n_fail++; $display("FAIL midop_busy: got %b, expected 11", {rs1_busy, rs2_busy}); end
      end
      tick();
    end
    idle(); cpu_rst = 1'b1;
    repeat (2) tick();
    cpu_rst = 1'b0;
    tick();
    n_checks++; if (lsu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL midop_ready: got %b, expected 1", lsu_wb_ready); end
    n_checks++; if ({rs1_busy, rs2_busy} !== 2'b00) begin n_fail++; $display("FAIL midop_busy_clr: got %b, expected 00", {rs1_busy, rs2_busy}); end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL midop_discard[%0d]: got %b, expected 0", i, wr_valid); end
      tick();
    end
  endtask

  initial begin
    cpu_rst = 1'b1; idle(); rs1_dec = '0; rs2_dec = '0;
    test_reset();
    test_alu();
    test_lsu_busy();
    test_back_to_back();
    test_starvation();
    test_priority();
    test_set_clear();
    test_reset_midop();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d writes outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of writeback data.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, consecutive cycles without an LSU pop before the ALU is stalled.
REQ-003 SHALL have port cpu_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port cpu_rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port alu_wb_valid, input, 1, single-cycle ALU result present.
REQ-006 SHALL have port alu_wb_rd, input, 5, ALU destination index.
REQ-007 SHALL have port alu_wb_data, input, DATA_WIDTH, ALU result.
REQ-008 SHALL have port alu_wb_stall, output, 1, ALU result not accepted this cycle; producer holds it.
REQ-009 SHALL have port lsu_issue_valid, input, 1, long-latency op issued this cycle.
REQ-010 SHALL have port lsu_issue_rd, input, 5, destination of the issued op.
REQ-011 SHALL have port lsu_wb_valid, input, 1, LSU/MULDIV result offered.
REQ-012 SHALL have port lsu_wb_ready, output, 1, result accepted when valid and ready are both high.
REQ-013 SHALL have port lsu_wb_rd, input, 5, LSU destination index.
REQ-014 SHALL have port lsu_wb_data, input, DATA_WIDTH, LSU result.
REQ-015 SHALL have port wr_valid, output, 1, register-file write strobe.
REQ-016 SHALL have port rd_wb, output, 5, register-file write index.
REQ-017 SHALL have port wr_data, output, DATA_WIDTH, register-file write data.
REQ-018 SHALL have ports rs1_dec and rs2_dec, input, 5 each, source indices in DEC.
REQ-019 SHALL have ports rs1_busy and rs2_busy, output, 1 each, source has a write pending.

Function
REQ-020 SHALL buffer accepted LSU results in a 2-entry FIFO with wrapping read/write pointers and a count of 0..2.
REQ-021 SHALL drive lsu_wb_ready = (count < 2) from registered count only; a same-cycle pop SHALL NOT free a slot.
REQ-022 SHALL, each cycle, select at most one winner: ALU if alu_wb_valid, alu_wb_rd != 0 and alu_wb_stall low; otherwise the FIFO head if count > 0.
REQ-023 SHALL treat an ALU request with rd = 0 as absent, so the FIFO may pop that cycle.
REQ-024 SHALL register the winner into wr_valid/rd_wb/wr_data at the edge; wr_valid SHALL be 0 in cycles with no winner.
REQ-025 SHALL pop a FIFO head with rd = 0 without asserting wr_valid.
REQ-026 SHALL have latency: ALU valid in cycle N -> wr_valid in N+1; LSU handshake in N into an empty FIFO, with no contention -> wr_valid in N+2.
REQ-027 SHALL not bypass FIFO data; an entry is poppable no earlier than the cycle after its push.
REQ-028 SHALL keep a starvation counter: increment when count > 0 and no pop occurs, saturate at STARVE_LIMIT, and clear on pop or when count = 0.
REQ-029 SHALL assert alu_wb_stall when the counter equals STARVE_LIMIT and count > 0; in that cycle the FIFO head wins.
REQ-030 SHALL keep a pending bitmap for x1..x31: set on lsu_issue_valid with lsu_issue_rd != 0; cleared when a FIFO entry with that rd pops.
REQ-031 SHALL give set priority over clear when both hit the same index in one cycle.
REQ-032 SHALL NOT let ALU writes alter the pending bitmap.
REQ-033 SHALL drive rs1_busy = pending[rs1_dec] and rs2_busy = pending[rs2_dec] combinationally; index 0 always reads 0.
REQ-034 SHALL hold push and pop atomic on simultaneous push and pop at count = 1; count stays 1.

Reset
REQ-035 SHALL, while cpu_rst is high, force count = 0, pointers = 0, pending = 0, starvation counter = 0, and wr_valid/rd_wb/wr_data = 0.
REQ-036 SHALL hold lsu_wb_ready and alu_wb_stall at 0 while cpu_rst is high; ready SHALL be 1 in the first cycle after release.
REQ-037 SHALL discard FIFO contents and pending bits on reset asserted mid-operation; no write SHALL issue for discarded entries.

Verification
REQ-038 SHALL test: ALU valid, rd = 5, data 0x1234 in cycle N -> wr_valid = 1, rd_wb = 5, wr_data = 0x1234 in N+1 only.
REQ-039 SHALL test: issue rd = 7 -> rs1_busy = 1 with rs1_dec = 7; LSU handshake rd = 7, 0xCAFE with idle ALU -> write in N+2, then rs1_busy = 0.
REQ-040 SHALL test: two LSU pushes while the ALU is valid every cycle -> lsu_wb_ready = 0; after 4 stalled cycles alu_wb_stall = 1 and the head is written.
REQ-041 SHALL test: ALU and FIFO head both present -> the ALU result is written first and the FIFO head the next cycle.
REQ-042 SHALL test: issue and pop of rd = 3 in the same cycle -> pending[3] stays 1.
REQ-043 SHALL test: reset with FIFO count = 2 -> no subsequent wr_valid, lsu_wb_ready = 1 after release, rs1_busy = rs2_busy = 0.
